pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM (or
// divided clock) input, in clk_i cycles.
//
// Ports
//   clk_i      single system clock, all logic on its rising edge
//   rstn_i     asynchronous active-low reset
//   en_i       capture enable; low returns to IDLE and clears the counters
//   pwm_i      asynchronous signal under measurement
//   period_o   clk_i cycles between consecutive synchronized rising edges
//   high_o     clk_i cycles the synchronized input was high in that period
//   valid_o    one-cycle pulse when period_o/high_o/timeout_o update
//   timeout_o  no rising edge for 2^WIDTH-1 cycles
//   state_o    current FSM state (IDLE=0, MEASURE=1, TIMEOUT=2), for debug
//
// Handshake: valid_o is a registered, push-only qualifier with no ready.
// It is high for exactly one cycle per result. period_o, high_o and
// timeout_o change only in the cycle valid_o is high, and they hold
// their values at all other times, so a consumer may sample them then.
module pwm_capture #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             pwm_i,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] high_o,
  output logic             valid_o,
  output logic             timeout_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;
  logic             sync_meta;
  logic             s;
  logic             s_prev;
  logic             rise;
  logic [WIDTH-1:0] per_cnt;
  logic [WIDTH-1:0] hi_cnt;
  logic [WIDTH-1:0] per_nxt;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic [WIDTH-1:0] high_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;

  // Two-flop synchronizer producing s, plus one more flop for edge detect.
  // These keep running regardless of en_i.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_meta <= 1'b0;
      s         <= 1'b0;
      s_prev    <= 1'b0;
    end else begin
      sync_meta <= pwm_i;
      s         <= sync_meta;
      s_prev    <= s;
    end
  end

  assign rise = s & ~s_prev;

  // State, counters and result registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      period_o  <= '0;
      high_o    <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      per_cnt   <= per_nxt;
      hi_cnt    <= hi_nxt;
      period_o  <= period_nxt;
      high_o    <= high_nxt;
      valid_o   <= valid_nxt;
      timeout_o <= timeout_nxt;
    end
  end

  // Next-state and next-output logic. Results hold unless a period
  // completes or the timeout fires. Disable takes priority over rise.
  always_comb begin
    state_nxt   = state;
    per_nxt     = per_cnt;
    hi_nxt      = hi_cnt;
    period_nxt  = period_o;
    high_nxt    = high_o;
    timeout_nxt = timeout_o;
    valid_nxt   = 1'b0;

    if (!en_i) begin
      state_nxt = IDLE;
      per_nxt   = '0;
      hi_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          per_nxt = '0;
          hi_nxt  = '0;
          // The first edge only opens a measurement window.
          if (rise) begin
            state_nxt = MEASURE;
            per_nxt   = ONE;
            hi_nxt    = ONE;
          end
        end

        MEASURE: begin
          // A rise in the same cycle the counter saturates still closes
          // the period normally.
          if (rise) begin
            period_nxt  = per_cnt;
            high_nxt    = hi_cnt;
            timeout_nxt = 1'b0;
            valid_nxt   = 1'b1;
            per_nxt     = ONE;
            hi_nxt      = ONE;
          end else if (per_cnt == ONES) begin
            // Saturated without an edge: report a timeout. The high time
            // reads full-scale if the input is stuck high, zero if low.
            state_nxt   = TIMEOUT;
            timeout_nxt = 1'b1;
            period_nxt  = '0;
            high_nxt    = s ? ONES : '0;
            valid_nxt   = 1'b1;
          end else begin
            // hi_cnt only advances alongside per_cnt, so it never
            // exceeds per_cnt and neither counter can wrap.
            per_nxt = per_cnt + ONE;
            if (s) begin
              hi_nxt = hi_cnt + ONE;
            end
          end
        end

        TIMEOUT: begin
          // Counters frozen. An edge restarts measurement. timeout_o stays
          // set until the next complete period is reported.
          if (rise) begin
            state_nxt = MEASURE;
            per_nxt   = ONE;
            hi_nxt    = ONE;
          end
        end

        default: begin
          state_nxt = IDLE;
          per_nxt   = '0;
          hi_nxt    = '0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule
